// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads words from a handshaked instruction
// memory, and presents a stable IR plus a one-cycle register write enable to the
// control unit. Supports branch redirect, read timeout/retry and a halt opcode.
module instr_fetch_unit #(
   parameter int unsigned ADDR_W       = 9,
   parameter int unsigned RESET_PC     = 0,
   parameter int unsigned WAIT_TIMEOUT = 15,
   parameter logic [4:0]  HALT_OPCODE  = 5'b11011
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_data,
   input  logic              mem_ack,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   input  logic              exec_done,
   output logic [31:0]       IR,
   output logic              ir_valid,
   output logic              wren,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic [15:0]       instr_count
);

   // Timeout counter only needs to reach WAIT_TIMEOUT-1.
   localparam int unsigned TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [TW-1:0] TimeoutLast = TW'(WAIT_TIMEOUT - 1);

   // Opcodes with no destination register.
   localparam logic [4:0] OpMul = 5'b01100;
   localparam logic [4:0] OpDiv = 5'b01101;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StIssue,
      StExec,
      StHalt
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [4:0]        opcode;
   logic              is_halt;
   logic              no_dest;

   assign opcode  = ir_q[31:27];
   assign is_halt = (opcode == HALT_OPCODE);
   assign no_dest = (opcode == OpMul) || (opcode == OpDiv);

   // FSM state register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (run) state_d = StReq;
         end
         StReq: begin
            state_d = StWait;
         end
         StWait: begin
            if (mem_ack) begin
               state_d = StIssue;
            end else if (tcnt_q == TimeoutLast) begin
               // Re-request the same word; pc is untouched.
               state_d = StReq;
            end
         end
         StIssue: begin
            state_d = is_halt ? StHalt : StExec;
         end
         StExec: begin
            if (exec_done) state_d = run ? StReq : StIdle;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM outputs, decoded from the current state.
   always_comb begin
      mem_rd   = 1'b0;
      mem_addr = '0;
      ir_valid = 1'b0;
      wren     = 1'b0;
      halted   = 1'b0;
      unique case (state_q)
         StReq: begin
            mem_rd   = 1'b1;
            mem_addr = pc_q;
         end
         StIssue: begin
            ir_valid = 1'b1;
            wren     = !is_halt && !no_dest;
         end
         StExec: begin
            ir_valid = 1'b1;
         end
         StHalt: begin
            halted = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath next-state: pc, IR, timeout counter and issue counter.
   always_comb begin
      pc_d   = pc_q;
      ir_d   = ir_q;
      tcnt_d = tcnt_q;
      cnt_d  = cnt_q;
      unique case (state_q)
         StReq: begin
            tcnt_d = '0;
         end
         StWait: begin
            if (mem_ack) begin
               ir_d = mem_data;
               pc_d = pc_q + ADDR_W'(1);
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         StIssue: begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
         end
         StExec: begin
            // Later redirects overwrite earlier ones until exec_done.
            if (pc_load) pc_d = pc_target;
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pc_q   <= ADDR_W'(RESET_PC);
         ir_q   <= '0;
         tcnt_q <= '0;
         cnt_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         ir_q   <= ir_d;
         tcnt_q <= tcnt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign IR          = ir_q;
   assign pc          = pc_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, basic fetch, mul/div, branch,
// timeout retry with pc wrap, mid-wait reset and halt.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        clr;
   logic        run;
   logic [8:0]  mem_addr;
   logic        mem_rd;
   logic [31:0] mem_data;
   logic        mem_ack;
   logic        pc_load;
   logic [8:0]  pc_target;
   logic        exec_done;
   logic [31:0] IR;
   logic        ir_valid;
   logic        wren;
   logic [8:0]  pc;
   logic        halted;
   logic [15:0] instr_count;

   int n_tests = 0;
   int n_fail  = 0;
   int rd_seen;
   int wr_seen;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_W      (9),
      .RESET_PC    (0),
      .WAIT_TIMEOUT(15),
      .HALT_OPCODE (5'b11011)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .run        (run),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .mem_ack    (mem_ack),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .exec_done  (exec_done),
      .IR         (IR),
      .ir_valid   (ir_valid),
      .wren       (wren),
      .pc         (pc),
      .halted     (halted),
      .instr_count(instr_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr       = 1'b0;
      run       = 1'b0;
      mem_ack   = 1'b1;
      mem_data  = 32'hDEAD_BEEF;
      pc_load   = 1'b0;
      pc_target = '0;
      exec_done = 1'b0;

      // Reset held with a stray ack
      repeat (3) tick();
      check("rst_ir",       IR,          32'h0);
      check("rst_mem_rd",   mem_rd,      1'b0);
      check("rst_mem_addr", mem_addr,    9'h0);
      check("rst_ir_valid", ir_valid,    1'b0);
      check("rst_wren",     wren,        1'b0);
      check("rst_pc",       pc,          9'h0);
      check("rst_halted",   halted,      1'b0);
      check("rst_count",    instr_count, 16'h0);

      // Release reset, start fetching
      clr     = 1'b1;
      mem_ack = 1'b0;
      run     = 1'b1;
      tick();  // REQ
      check("first_rd",   mem_rd,   1'b1);
      check("first_addr", mem_addr, 9'h000);
      tick();  // WAIT 1
      check("rd_one_cycle", mem_rd, 1'b0);
      tick();  // WAIT 2, ack now
      mem_ack  = 1'b1;
      mem_data = 32'h0888_0000;
      tick();  // ISSUE
      mem_ack = 1'b0;
      check("basic_ir",    IR,       32'h0888_0000);
      check("basic_wren",  wren,     1'b1);
      check("basic_valid", ir_valid, 1'b1);
      check("basic_pc",    pc,       9'h001);
      tick();  // EXEC
      check("basic_wren_off", wren,        1'b0);
      check("basic_valid_ex", ir_valid,    1'b1);
      check("basic_count",    instr_count, 16'd1);
      exec_done = 1'b1;
      tick();  // REQ
      exec_done = 1'b0;
      check("next_rd",      mem_rd,   1'b1);
      check("next_addr",    mem_addr, 9'h001);
      check("valid_retire", ir_valid, 1'b0);

      // Mul: no destination register
      tick();  // WAIT
      mem_ack  = 1'b1;
      mem_data = 32'h6000_0000;
      tick();  // ISSUE
      mem_ack = 1'b0;
      check("mul_ir",    IR,       32'h6000_0000);
      check("mul_valid", ir_valid, 1'b1);
      check("mul_wren",  wren,     1'b0);
      tick();  // EXEC
      check("mul_wren_ex", wren,        1'b0);
      check("mul_count",   instr_count, 16'd2);
      exec_done = 1'b1;
      tick();  // REQ
      exec_done = 1'b0;
      check("div_addr", mem_addr, 9'h002);

      // Div: no destination register
      tick();  // WAIT
      mem_ack  = 1'b1;
      mem_data = 32'h6800_0000;
      tick();  // ISSUE
      mem_ack = 1'b0;
      check("div_ir",    IR,       32'h6800_0000);
      check("div_valid", ir_valid, 1'b1);
      check("div_wren",  wren,     1'b0);
      check("div_pc",    pc,       9'h003);
      tick();  // EXEC

      // Branch together with exec_done
      pc_load   = 1'b1;
      pc_target = 9'h040;
      exec_done = 1'b1;
      tick();  // REQ
      pc_load   = 1'b0;
      exec_done = 1'b0;
      check("branch_rd",   mem_rd,   1'b1);
      check("branch_addr", mem_addr, 9'h040);

      // Redirect outside EXEC is ignored
      tick();  // WAIT
      pc_load   = 1'b1;
      pc_target = 9'h123;
      mem_ack   = 1'b1;
      mem_data  = 32'h0888_0000;
      tick();  // ISSUE
      pc_load = 1'b0;
      mem_ack = 1'b0;
      check("ignore_load_pc", pc, 9'h041);
      tick();  // EXEC

      // Two redirects in EXEC, last wins; ack in EXEC must not disturb IR
      pc_load   = 1'b1;
      pc_target = 9'h100;
      mem_ack   = 1'b1;
      mem_data  = 32'hFFFF_FFFF;
      tick();
      check("exec_load1_pc", pc, 9'h100);
      pc_target = 9'h1FF;
      tick();
      check("exec_load2_pc", pc,       9'h1FF);
      check("exec_ir_hold",  IR,       32'h0888_0000);
      check("exec_valid",    ir_valid, 1'b1);
      pc_load   = 1'b0;
      mem_ack   = 1'b0;
      exec_done = 1'b1;
      tick();  // REQ
      exec_done = 1'b0;
      check("last_load_addr", mem_addr, 9'h1FF);
      check("count_four",     instr_count, 16'd4);

      // Timeout: 15 WAIT cycles without ack, then re-request same address
      rd_seen = 0;
      repeat (15) begin
         tick();
         if (mem_rd) rd_seen++;
      end
      check("no_rd_in_wait", rd_seen, 0);
      tick();  // REQ again
      check("retry_rd",   mem_rd,   1'b1);
      check("retry_addr", mem_addr, 9'h1FF);
      tick();  // WAIT
      mem_ack  = 1'b1;
      mem_data = 32'h0888_0000;
      tick();  // ISSUE
      mem_ack = 1'b0;
      check("wrap_pc", pc, 9'h000);
      tick();  // EXEC
      exec_done = 1'b1;
      tick();  // REQ
      exec_done = 1'b0;
      check("wrap_addr", mem_addr, 9'h000);
      tick();  // WAIT

      // Reset mid-WAIT, then a late ack must be ignored
      clr = 1'b0;
      #1;
      check("midrst_rd",    mem_rd,      1'b0);
      check("midrst_count", instr_count, 16'h0);
      run = 1'b0;
      tick();
      clr      = 1'b1;
      mem_ack  = 1'b1;
      mem_data = 32'h0888_0000;
      tick();
      tick();
      check("late_ack_ir",    IR,       32'h0);
      check("late_ack_valid", ir_valid, 1'b0);
      check("late_ack_pc",    pc,       9'h000);
      check("idle_no_rd",     mem_rd,   1'b0);
      mem_ack = 1'b0;

      // Halt opcode
      run = 1'b1;
      tick();  // REQ
      check("halt_req_rd", mem_rd, 1'b1);
      tick();  // WAIT
      mem_ack  = 1'b1;
      mem_data = 32'hD800_0000;
      tick();  // ISSUE
      mem_ack = 1'b0;
      check("halt_ir",   IR,   32'hD800_0000);
      check("halt_wren", wren, 1'b0);
      tick();  // HALT
      check("halted",       halted,      1'b1);
      check("halt_valid",   ir_valid,    1'b0);
      check("halt_count",   instr_count, 16'd1);
      rd_seen = 0;
      wr_seen = 0;
      repeat (50) begin
         tick();
         if (mem_rd) rd_seen++;
         if (wren) wr_seen++;
      end
      check("halt_no_rd",   rd_seen, 0);
      check("halt_no_wren", wr_seen, 0);
      check("halt_stays",   halted,  1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the register/ALU control unit. It holds the PC, reads instruction words from a handshaked instruction memory, and presents a stable 32-bit IR to the control unit. It also drives the control unit's register write-enable (wren) and waits for an execute-done handshake before fetching the next word. It handles PC redirect, memory timeout/retry and a halt opcode.

Parameters:
ADDR_W, 9, word-address width of instruction memory (512 words)
RESET_PC, 0, PC value after reset
WAIT_TIMEOUT, 15, cycles in WAIT without mem_ack before the read is re-requested
HALT_OPCODE, 5'b11011, IR[31:27] value that halts fetching

Ports:
clk  in  1  system clock; all state changes on rising edge
clr  in  1  asynchronous, active-low reset
run  in  1  fetch enable
mem_addr  out  ADDR_W  instruction word address
mem_rd  out  1  read request strobe, exactly one cycle per request
mem_data  in  32  instruction word, valid when mem_ack=1
mem_ack  in  1  read response valid
pc_load  in  1  branch redirect request
pc_target  in  ADDR_W  redirect address
exec_done  in  1  control unit finished current instruction
IR  out  32  instruction register to control unit (opcode IR[31:27], dest IR[26:23], A IR[22:19], B IR[18:15])
ir_valid  out  1  IR holds an issued, not-yet-retired instruction
wren  out  1  register-file write enable to control unit, one-cycle pulse
pc  out  ADDR_W  current PC (address of next fetch)
halted  out  1  halt opcode reached
instr_count  out  16  issued-instruction count, saturating

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, pc=RESET_PC, IR=0, mem_addr=0, mem_rd=0, ir_valid=0, wren=0, halted=0, instr_count=0, timeout counter=0. Reset mid-transaction abandons it; later mem_ack is ignored until a new REQ.
- States: IDLE, REQ, WAIT, ISSUE, EXEC, HALT.
- IDLE: outputs idle; run=1 -> REQ next cycle.
- REQ: mem_rd=1, mem_addr=pc for one cycle; timeout counter cleared -> WAIT.
- WAIT: mem_rd=0. mem_ack=1 -> IR<=mem_data, pc<=pc+1 (mod 2^ADDR_W, so 511 wraps to 0) -> ISSUE. Without ack the counter increments; after WAIT_TIMEOUT cycles with no ack -> REQ (same pc). Only the first ack in WAIT is accepted; mem_ack in any other state is ignored.
- ISSUE (one cycle): ir_valid=1; instr_count+1, saturating at 16'hFFFF.
  - IR[31:27]==HALT_OPCODE -> HALT, wren=0.
  - Otherwise wren=1, except opcode 5'b01100 (mul) or 5'b01101 (div), where wren=0 because they have no destination register. -> EXEC.
- EXEC: ir_valid=1, wren=0, IR stable.
  - pc_load=1 in EXEC -> pc<=pc_target; the last pc_load before exec_done wins.
  - exec_done=1 -> ir_valid=0 next cycle; run=1 -> REQ, else -> IDLE.
  - pc_load and exec_done in the same cycle: redirect applies, and the next REQ uses pc_target.
  - pc_load outside EXEC is ignored.
- HALT: halted=1, ir_valid=0, no memory requests; leaves only on reset.
- run=0 is checked only in IDLE and on exit from EXEC. An in-flight fetch always completes through EXEC.
- Minimum instruction period: REQ, WAIT(ack same cycle), ISSUE, EXEC(done) = 4 cycles.

Test Plan:
- Reset: hold clr=0, toggle clk and drive mem_ack=1 -> all outputs zero, pc=0; release clr, run=1 -> mem_rd pulses 1 cycle later with mem_addr=0.
- Basic fetch: ack 2 cycles after mem_rd, mem_data=32'h0888_0000 -> IR=32'h0888_0000, wren high exactly one cycle, pc=1, instr_count=1; exec_done -> next mem_rd at addr 1.
- Mul/div: mem_data=32'h6000_0000 (opcode 01100) -> ir_valid=1, wren stays 0; same for 32'h6800_0000.
- Branch: in EXEC, pc_load=1 with pc_target=9'h040 in the same cycle as exec_done -> next mem_addr=9'h040.
- Timeout and wrap: set pc to 511 via redirect, withhold ack 15 cycles -> second mem_rd at 511; ack -> pc=0. Also assert clr mid-WAIT -> IDLE, and a late ack is ignored.
- Halt: mem_data=32'hD800_0000 -> halted=1, wren=0, no further mem_rd for 50 cycles with run=1.
